// File: rtl/rv32im_decode.sv
// RV32IM decode stage: register file with write-through bypass, instruction
// type/immediate decode, load-use hazard detection and the ID/EX register.
module rv32im_decode #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic [31:0] IF_ID_IR,
    input  logic [31:0] IF_PC,
    input  logic        IF_TAKEN_BRANCH,
    input  logic        IF_valid,
    input  logic        STALL,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        HALTED,
    output logic        ID_EX_valid,
    output logic [31:0] ID_EX_IR,
    output logic [31:0] ID_EX_PC,
    output logic        ID_EX_pred,
    output logic [31:0] ID_EX_A,
    output logic [31:0] ID_EX_B,
    output logic [31:0] ID_EX_IMM,
    output logic [4:0]  ID_EX_rs1,
    output logic [4:0]  ID_EX_rs2,
    output logic [4:0]  ID_EX_rd,
    output logic [2:0]  ID_EX_type,
    output logic        ID_EX_mem_read,
    output logic        ID_EX_mem_write,
    output logic        ID_EX_reg_write,
    output logic        ID_EX_muldiv,
    output logic        ID_EX_illegal
);

    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                           T_U = 3'd4, T_J = 3'd5, T_ILL = 3'd7;

    localparam logic [6:0] OP_REG  = 7'b0110011, OP_IMM  = 7'b0010011,
                           OP_LOAD = 7'b0000011, OP_JALR = 7'b1100111,
                           OP_STORE= 7'b0100011, OP_BR   = 7'b1100011,
                           OP_LUI  = 7'b0110111, OP_AUIPC= 7'b0010111,
                           OP_JAL  = 7'b1101111;

    typedef struct packed {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] pc;
        logic        pred;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  typ;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        muldiv;
        logic        illegal;
    } id_ex_t;

    // Bubble: everything zero except the encoding, which reads as a NOP.
    localparam id_ex_t BUBBLE = '{ir: NOP_INSTR, default: '0};

    logic [31:0] regs [0:31];
    id_ex_t      q, d;
    logic [6:0]  opcode;
    logic        use1, use2, rd_ok;

    assign opcode = IF_ID_IR[6:0];

    // Register file: x0 is never written; reset clears every entry.
    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Decode IF_ID_IR into the next ID/EX contents.
    always_comb begin
        d        = '0;
        use1     = 1'b0;
        use2     = 1'b0;
        rd_ok    = 1'b0;
        d.valid  = 1'b1;
        d.ir     = IF_ID_IR;
        d.pc     = IF_PC;
        unique case (opcode)
            OP_REG:                    begin d.typ = T_R; use1 = 1'b1; use2 = 1'b1; rd_ok = 1'b1; end
            OP_IMM, OP_LOAD, OP_JALR:  begin d.typ = T_I; use1 = 1'b1; rd_ok = 1'b1; end
            OP_STORE:                  begin d.typ = T_S; use1 = 1'b1; use2 = 1'b1; end
            OP_BR:                     begin d.typ = T_B; use1 = 1'b1; use2 = 1'b1; end
            OP_LUI, OP_AUIPC:          begin d.typ = T_U; rd_ok = 1'b1; end
            OP_JAL:                    begin d.typ = T_J; rd_ok = 1'b1; end
            default:                   d.typ = T_ILL;
        endcase
        unique case (d.typ)
            T_I:     d.imm = {{20{IF_ID_IR[31]}}, IF_ID_IR[31:20]};
            T_S:     d.imm = {{20{IF_ID_IR[31]}}, IF_ID_IR[31:25], IF_ID_IR[11:7]};
            T_B:     d.imm = {{19{IF_ID_IR[31]}}, IF_ID_IR[31], IF_ID_IR[7],
                              IF_ID_IR[30:25], IF_ID_IR[11:8], 1'b0};
            T_U:     d.imm = {IF_ID_IR[31:12], 12'b0};
            T_J:     d.imm = {{11{IF_ID_IR[31]}}, IF_ID_IR[31], IF_ID_IR[19:12],
                              IF_ID_IR[20], IF_ID_IR[30:21], 1'b0};
            default: d.imm = '0;
        endcase
        // Register indices are reported only where the format actually uses them,
        // so an unused field can never match a hazard or show a stale operand.
        d.rs1       = use1  ? IF_ID_IR[19:15] : 5'd0;
        d.rs2       = use2  ? IF_ID_IR[24:20] : 5'd0;
        d.rd        = rd_ok ? IF_ID_IR[11:7]  : 5'd0;
        d.a         = (d.rs1 == 5'd0) ? 32'd0 :
                      (wb_en && wb_rd == d.rs1) ? wb_data : regs[d.rs1];
        d.b         = (d.rs2 == 5'd0) ? 32'd0 :
                      (wb_en && wb_rd == d.rs2) ? wb_data : regs[d.rs2];
        d.mem_read  = (opcode == OP_LOAD);
        d.mem_write = (d.typ == T_S);
        d.reg_write = rd_ok && (d.rd != 5'd0);
        d.muldiv    = (opcode == OP_REG) && (IF_ID_IR[31:25] == 7'b0000001);
        d.illegal   = (d.typ == T_ILL);
        d.pred      = (d.typ == T_B || d.typ == T_J) ? IF_TAKEN_BRANCH : 1'b0;
    end

    // Load-use hazard: the load in ID/EX writes a register this instruction reads.
    always_comb begin
        HALTED = !STALL && IF_valid && q.valid && q.mem_read && (q.rd != 5'd0) &&
                 ((d.rs1 == q.rd) || (d.rs2 == q.rd));
    end

    // ID/EX register: reset, flush, hazard and empty fetch all insert a bubble.
    always_ff @(posedge clk) begin
        if (RESET)                             q <= BUBBLE;
        else if (STALL || HALTED || !IF_valid) q <= BUBBLE;
        else                                   q <= d;
    end

    assign ID_EX_valid     = q.valid;
    assign ID_EX_IR        = q.ir;
    assign ID_EX_PC        = q.pc;
    assign ID_EX_pred      = q.pred;
    assign ID_EX_A         = q.a;
    assign ID_EX_B         = q.b;
    assign ID_EX_IMM       = q.imm;
    assign ID_EX_rs1       = q.rs1;
    assign ID_EX_rs2       = q.rs2;
    assign ID_EX_rd        = q.rd;
    assign ID_EX_type      = q.typ;
    assign ID_EX_mem_read  = q.mem_read;
    assign ID_EX_mem_write = q.mem_write;
    assign ID_EX_reg_write = q.reg_write;
    assign ID_EX_muldiv    = q.muldiv;
    assign ID_EX_illegal   = q.illegal;

endmodule

// File: doc/rv32im_decode.md
RV32IM_DECODE -- requirements
Module: rv32im_decode

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000013, encoding reported in ID_EX_IR for bubbles.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 RESET  in  1  reset, synchronous, active-high.
REQ-004 IF_ID_IR  in  32  instruction from fetch stage.
REQ-005 IF_PC  in  32  PC of IF_ID_IR.
REQ-006 IF_TAKEN_BRANCH  in  1  fetch prediction for IF_ID_IR.
REQ-007 IF_valid  in  1  IF_ID_IR/IF_PC/IF_TAKEN_BRANCH valid this cycle.
REQ-008 STALL  in  1  control-hazard flush from fetch (mispredict).
REQ-009 wb_en  in  1  writeback enable; wb_rd  in  5; wb_data  in  32.
REQ-010 HALTED  out  1  load-use hazard, to fetch; combinational.
REQ-011 ID_EX_valid  out  1; ID_EX_IR  out  32; ID_EX_PC  out  32; ID_EX_pred  out  1.
REQ-012 ID_EX_A, ID_EX_B  out  32 each  rs1/rs2 operand values; ID_EX_IMM  out  32  sign-extended immediate.
REQ-013 ID_EX_rs1, ID_EX_rs2, ID_EX_rd  out  5 each.
REQ-014 ID_EX_type  out  3  R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7.
REQ-015 ID_EX_mem_read, ID_EX_mem_write, ID_EX_reg_write, ID_EX_muldiv, ID_EX_illegal  out  1 each.

Function
REQ-016 Register file: 32x32, x0 reads 0 always; write of x0 ignored.
REQ-017 Write at clk edge when wb_en; same-cycle read of wb_rd (rd!=0) returns wb_data (write-through bypass).
REQ-018 Type decode by opcode [6:0]: 0110011 R; 0010011/0000011/1100111 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; any other opcode ILLEGAL.
REQ-019 IMM: I={20{ir[31]},ir[31:20]}; S={20{ir[31]},ir[31:25],ir[11:7]}; B={19{ir[31]},ir[31],ir[7],ir[30:25],ir[11:8],0}; U={ir[31:12],12'b0}; J={11{ir[31]},ir[31],ir[19:12],ir[20],ir[30:21],0}; R/ILLEGAL=0.
REQ-020 mem_read=(opcode 0000011); mem_write=type S; reg_write=type R, I, U or J with rd!=0; muldiv=opcode 0110011 and funct7 0000001.
REQ-021 rs1 used for R, I, S, B; rs2 used for R, S, B only.
REQ-022 Load-use: HALTED=1 when IF_valid, ID_EX_valid, ID_EX_mem_read, ID_EX_rd!=0, and ID_EX_rd equals a used rs of IF_ID_IR; STALL=1 forces HALTED=0.
REQ-023 Latency 1 cycle: decoded IF_ID_IR appears on ID_EX_* at next clk edge.
REQ-024 Priority per edge: RESET > STALL > HALTED > normal.
REQ-025 STALL=1: bubble inserted (ID_EX_valid=0, ID_EX_IR=NOP_INSTR, all control flags 0); regfile writeback still performed.
REQ-026 HALTED=1: bubble inserted as REQ-025; fetch holds IF_ID_IR, so it re-decodes next cycle.
REQ-027 IF_valid=0: bubble inserted.
REQ-028 ILLEGAL: ID_EX_valid=1, ID_EX_illegal=1, reg_write/mem_read/mem_write=0.
REQ-029 ID_EX_pred=IF_TAKEN_BRANCH for type B or J, else 0.

Reset
REQ-030 RESET=1 at edge: all 32 registers=0, ID_EX_valid=0, ID_EX_IR=NOP_INSTR, all other ID_EX_* =0.
REQ-031 RESET mid-hazard discards pending bubble state; HALTED=0 in the first cycle after reset.
REQ-032 wb_en during RESET ignored.

Verification
REQ-033 Write x5=0x12345678 via wb, then IF_ID_IR=add x6,x5,x0 (0x00028333) -> next cycle ID_EX_A=0x12345678, ID_EX_B=0, type=0, reg_write=1, rd=6.
REQ-034 IF_ID_IR=beq x1,x2,-8 (0xFE208CE3), IF_TAKEN_BRANCH=1 -> ID_EX_IMM=0xFFFFFFF8, type=3, pred=1, reg_write=0.
REQ-035 lw x7,0(x1) then add x8,x7,x7 -> HALTED=1 one cycle, bubble in ID_EX, add issued next cycle with ID_EX_valid=1.
REQ-036 STALL=1 with valid jal (0x008000EF) -> ID_EX_valid=0, ID_EX_IR=0x00000013; STALL concurrent with load-use -> HALTED=0.
REQ-037 wb_en=1, wb_rd=0, wb_data=0xFFFFFFFF, then read x0 -> ID_EX_A=0; same-cycle wb to x9 and read x9 -> bypassed value.
REQ-038 IF_ID_IR=0xFFFFFFFF -> ID_EX_illegal=1, type=7, IMM=0; mul x3,x1,x2 (0x022081B3) -> muldiv=1.
